mc_controller: RTL

//  Multicycle control unit for the ARM-subset processor: sequences the shared datapath
//  (one memory, one ALU) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps.

---
 rtl/mc_ctrl_pkg.sv | 79 +++++++
 rtl/mc_ctrl_if.sv | 59 +++++
 rtl/mc_condlogic.sv | 37 +++
 rtl/mc_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, ALU, opcode and condition encodings for the multicycle controller
package mc_ctrl_pkg;

    // Controller states; values are fixed so waveforms and debug taps stay stable
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // ALUControl codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Instruction class, Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // Data-processing commands, Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes, Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Evaluate an ARM condition against NZCV; the reserved code 1111 never passes
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, res;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - controller <-> datapath signal bundle; mem_ready exists only with MC_CTRL_STALL_EN
interface mc_ctrl_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
`ifdef MC_CTRL_STALL_EN
    logic        mem_ready;
`endif
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic        RegWrite;

    // Controller side
    modport master (
        input  Instr,
        input  ALUFlags,
`ifdef MC_CTRL_STALL_EN
        input  mem_ready,
`endif
        output PCWrite,
        output AdrSrc,
        output MemWrite,
        output IRWrite,
        output ResultSrc,
        output ALUSrcA,
        output ALUSrcB,
        output ALUControl,
        output ImmSrc,
        output RegSrc,
        output RegWrite
    );

    // Datapath side
    modport slave (
        output Instr,
        output ALUFlags,
`ifdef MC_CTRL_STALL_EN
        output mem_ready,
`endif
        input  PCWrite,
        input  AdrSrc,
        input  MemWrite,
        input  IRWrite,
        input  ResultSrc,
        input  ALUSrcA,
        input  ALUSrcB,
        input  ALUControl,
        input  ImmSrc,
        input  RegSrc,
        input  RegWrite
    );
endinterface

// File: rtl/mc_condlogic.sv
// rtl/mc_condlogic.sv - NZCV flag register, condition evaluation and latched condition result
module mc_condlogic
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_cond_load,
    input  logic       i_flags_wr,
    input  logic       i_cv_wr,
    output logic       o_cond_q
);
    logic [3:0] r_flags;
    logic       r_cond_q;
    logic       w_wr_nz;
    logic       w_wr_cv;

    // An instruction that failed its condition must never touch the flags
    assign w_wr_nz  = i_flags_wr & r_cond_q;
    assign w_wr_cv  = w_wr_nz & i_cv_wr;
    assign o_cond_q = r_cond_q;

    // Flag register and condition latch; condition sampled from the flags as they stand in DECODE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags  <= FLAGS_RST;
            r_cond_q <= 1'b0;
        end else begin
            if (i_cond_load) r_cond_q <= cond_eval(i_cond, r_flags);
            if (w_wr_nz)     r_flags[3:2] <= i_alu_flags[3:2];
            if (w_wr_cv)     r_flags[1:0] <= i_alu_flags[1:0];
        end
    end
endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM-subset control FSM and decode; MC_CTRL_STALL_EN adds memory-ready stalls
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'h0
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    localparam logic [3:0] ST_FETCH    = S_FETCH;
    localparam logic [3:0] ST_DECODE   = S_DECODE;
    localparam logic [3:0] ST_MEMADR   = S_MEMADR;
    localparam logic [3:0] ST_MEMREAD  = S_MEMREAD;
    localparam logic [3:0] ST_MEMWB    = S_MEMWB;
    localparam logic [3:0] ST_MEMWRITE = S_MEMWRITE;
    localparam logic [3:0] ST_EXECUTER = S_EXECUTER;
    localparam logic [3:0] ST_EXECUTEI = S_EXECUTEI;
    localparam logic [3:0] ST_ALUWB    = S_ALUWB;
    localparam logic [3:0] ST_BRANCH   = S_BRANCH;

    logic [3:0] r_state;
    logic [3:0] w_state_nxt;

    // Instruction fields; Instr carries bits [31:12], so index = bit - 12
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_imm;
    logic [3:0] w_cmd;
    logic       w_s;
    logic [3:0] w_rd;
    logic       w_unused;

    assign w_cond   = bus.Instr[19:16];
    assign w_op     = bus.Instr[15:14];
    assign w_imm    = bus.Instr[13];
    assign w_cmd    = bus.Instr[12:9];
    assign w_s      = bus.Instr[8];
    assign w_rd     = bus.Instr[3:0];
    assign w_unused = &{1'b0, bus.Instr[7:4]};

    logic w_mem_ready;
`ifdef MC_CTRL_STALL_EN
    assign w_mem_ready = bus.mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    // Data-processing command decode; unknown commands fall through as NOPs
    logic [1:0] w_alu_op;
    logic       w_cmd_valid;
    logic       w_nowrite;
    logic       w_cv_op;

    // Map cmd to ALU operation, write-back suppression and carry/overflow relevance
    always_comb begin
        w_alu_op    = ALU_ADD;
        w_cmd_valid = 1'b1;
        w_nowrite   = 1'b0;
        w_cv_op     = 1'b0;
        case (w_cmd)
            CMD_ADD: begin w_alu_op = ALU_ADD; w_cv_op = 1'b1; end
            CMD_SUB: begin w_alu_op = ALU_SUB; w_cv_op = 1'b1; end
            CMD_AND: w_alu_op = ALU_AND;
            CMD_ORR: w_alu_op = ALU_ORR;
            CMD_CMP: begin w_alu_op = ALU_SUB; w_cv_op = 1'b1; w_nowrite = 1'b1; end
            default: w_cmd_valid = 1'b0;
        endcase
    end

    logic w_cond_q;
    logic w_in_exec;

    assign w_in_exec = (r_state == ST_EXECUTER) || (r_state == ST_EXECUTEI);

    mc_condlogic #(
        .FLAGS_RST (FLAGS_RST)
    ) u_cond (
        .clk         (clk),
        .reset       (reset),
        .i_cond      (w_cond),
        .i_alu_flags (bus.ALUFlags),
        .i_cond_load (r_state == ST_DECODE),
        .i_flags_wr  (w_in_exec & w_s),
        .i_cv_wr     (w_cv_op),
        .o_cond_q    (w_cond_q)
    );

    // Next-state selection; memory-facing states wait on mem_ready when stalls are enabled
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: if (w_mem_ready) w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (w_op)
                    OP_MEM: w_state_nxt = ST_MEMADR;
                    OP_DP: begin
                        if (!w_cmd_valid) w_state_nxt = ST_FETCH;
                        else if (w_imm)   w_state_nxt = ST_EXECUTEI;
                        else              w_state_nxt = ST_EXECUTER;
                    end
                    OP_B:   w_state_nxt = ST_BRANCH;
                    OP_UND: w_state_nxt = ST_FETCH;
                endcase
            end
            ST_MEMADR:   w_state_nxt = w_s ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  if (w_mem_ready) w_state_nxt = ST_MEMWB;
            ST_MEMWRITE: if (w_mem_ready) w_state_nxt = ST_FETCH;
            ST_EXECUTER: w_state_nxt = ST_ALUWB;
            ST_EXECUTEI: w_state_nxt = ST_ALUWB;
            ST_MEMWB:    w_state_nxt = ST_FETCH;
            ST_ALUWB:    w_state_nxt = ST_FETCH;
            ST_BRANCH:   w_state_nxt = ST_FETCH;
            default:     w_state_nxt = ST_FETCH;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_FETCH;
        else        r_state <= w_state_nxt;
    end

    logic       w_pcwrite;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic [1:0] w_resultsrc;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_alucontrol;
    logic       w_regwrite;

    // Per-state datapath controls; anything not set stays 0 / ADD
    always_comb begin
        w_pcwrite    = 1'b0;
        w_adrsrc     = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_resultsrc  = 2'b00;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_alucontrol = ALU_ADD;
        w_regwrite   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = w_mem_ready;
                w_pcwrite   = w_mem_ready;
            end
            ST_DECODE: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            ST_MEMADR:  w_alusrcb = 2'b01;
            ST_MEMREAD: w_adrsrc  = 1'b1;
            ST_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = w_cond_q;
            end
            ST_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = w_cond_q;
            end
            ST_EXECUTER: begin
                w_alusrcb    = 2'b00;
                w_alucontrol = w_alu_op;
            end
            ST_EXECUTEI: begin
                w_alusrcb    = 2'b01;
                w_alucontrol = w_alu_op;
            end
            ST_ALUWB: begin
                w_resultsrc = 2'b00;
                // Writes to r15 redirect the PC instead of the register file
                if (w_rd == 4'hF) w_pcwrite  = w_cond_q & ~w_nowrite;
                else              w_regwrite = w_cond_q & ~w_nowrite;
            end
            ST_BRANCH: begin
                w_alusrcb   = 2'b01;
                w_resultsrc = 2'b10;
                w_pcwrite   = w_cond_q;
            end
            default: ;
        endcase
    end

    // Write enables are held off combinationally for as long as reset is low
    assign bus.PCWrite    = w_pcwrite  & reset;
    assign bus.IRWrite    = w_irwrite  & reset;
    assign bus.MemWrite   = w_memwrite & reset;
    assign bus.RegWrite   = w_regwrite & reset;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ALUControl = w_alucontrol;
    assign bus.ImmSrc     = w_op;
    assign bus.RegSrc     = {(w_op == OP_MEM) & ~w_s, (w_op == OP_B)};
endmodule
